// File: rtl/sd_spi_card_responder_if.sv
// rtl/sd_spi_card_responder_if.sv - SPI pins and backing-memory port of the SD card responder
interface sd_spi_card_responder_if;
  logic        spi_clk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic [31:0] blk_addr;
  logic [8:0]  mem_idx;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic        initialized;
  logic        cmd_strobe;
  logic [5:0]  cmd_index;

  // Card side
  modport slave (
    input  spi_clk, cs, mosi, mem_rd_data,
    output miso, blk_addr, mem_idx, mem_wr_en, mem_wr_data, initialized, cmd_strobe, cmd_index
  );

  // Host / memory side
  modport master (
    output spi_clk, cs, mosi, mem_rd_data,
    input  miso, blk_addr, mem_idx, mem_wr_en, mem_wr_data, initialized, cmd_strobe, cmd_index
  );
endinterface

// File: rtl/sd_spi_card_responder.sv
// rtl/sd_spi_card_responder.sv - SPI-mode SD card responder with block read/write backing memory
module sd_spi_card_responder #(
  parameter int NCR_BYTES      = 1,
  parameter int ACMD41_RETRIES = 2,
  parameter int RD_GAP_BYTES   = 2,
  parameter int BUSY_BYTES     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  sd_spi_card_responder_if.slave bus
);
  localparam logic [9:0] NCR_LAST   = 10'(NCR_BYTES - 1);
  localparam logic [9:0] GAP_LAST   = 10'(RD_GAP_BYTES - 1);
  localparam logic [9:0] BUSY_LAST  = 10'(BUSY_BYTES - 1);
  localparam logic [7:0] RETRY_INIT = 8'(ACMD41_RETRIES);

  typedef enum logic [3:0] {
    CMD_RX, RSP_GAP, RSP_TX, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
  } state_t;
  typedef enum logic [1:0] {POST_NONE, POST_RD, POST_WR} post_t;

  logic [1:0] sclk_q, cs_q, mosi_q;
  logic       sclk_d, cs_d;
  logic       sclk_rise, sclk_fall, cs_fall, cs_hi, byte_done;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] rx_byte, tx_sr, tx_next, tx_next_q;
  logic       load_pend;

  state_t     state, state_n;
  logic [9:0] cnt, cnt_n;
  logic [2:0] frame_cnt, frame_n;
  logic       cmd_done, rd_adv, wr_stb;

  logic [5:0]       cmd_idx_q;
  logic [31:0]      arg_q;
  logic             init_q, app_flag;
  logic [7:0]       acmd_cnt;
  logic [7:0][7:0]  rsp_q;
  logic [2:0]       rsp_last;
  post_t            post;

  logic             illegal, init_n;
  logic [7:0]       acmd_n;
  logic [7:0][7:0]  rsp_n;
  logic [2:0]       last_n;
  post_t            post_n;

  logic [31:0] blk_addr_q;
  logic [8:0]  mem_idx_q;
  logic        wr_en_q, strobe_q;
  logic [7:0]  wr_data_q;
  logic [5:0]  cmd_index_q;

  assign sclk_rise = sclk_q[1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[1] & sclk_d;
  assign cs_hi     = cs_q[1];
  assign cs_fall   = cs_d & ~cs_q[1];
  assign byte_done = sclk_rise & ~cs_hi & ~cs_fall & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr, mosi_q[1]};

  // Two-flop synchronizers on the SPI pins plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 2'b00; cs_q <= 2'b11; mosi_q <= 2'b00;
      sclk_d <= 1'b0;  cs_d <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[0], bus.spi_clk};
      cs_q   <= {cs_q[0], bus.cs};
      mosi_q <= {mosi_q[0], bus.mosi};
      sclk_d <= sclk_q[1];
      cs_d   <= cs_q[1];
    end
  end

  // Byte engine: sample mosi on rise, shift miso on fall, load the next byte on the fall after byte_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 3'd0; rx_sr <= 7'd0; tx_sr <= 8'hFF; tx_next_q <= 8'hFF; load_pend <= 1'b0;
    end else if (cs_hi || cs_fall) begin
      bit_cnt <= 3'd0; tx_sr <= 8'hFF; load_pend <= 1'b0;
    end else begin
      if (sclk_rise) begin
        rx_sr   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        tx_next_q <= tx_next;
        load_pend <= 1'b1;
      end
      if (sclk_fall) begin
        if (load_pend) begin
          tx_sr     <= tx_next_q;
          load_pend <= 1'b0;
        end else begin
          tx_sr <= {tx_sr[6:0], 1'b1};
        end
      end
    end
  end

  // FSM state register; chip select high parks the protocol in CMD_RX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CMD_RX; cnt <= 10'd0; frame_cnt <= 3'd0;
    end else if (cs_hi) begin
      state <= CMD_RX; cnt <= 10'd0; frame_cnt <= 3'd0;
    end else if (byte_done) begin
      state <= state_n; cnt <= cnt_n; frame_cnt <= frame_n;
    end
  end

  // Next state and the byte to send in the following slot, evaluated at byte_done
  always_comb begin
    state_n = state; cnt_n = cnt; frame_n = frame_cnt; tx_next = 8'hFF;
    cmd_done = 1'b0; rd_adv = 1'b0; wr_stb = 1'b0;
    case (state)
      CMD_RX: begin
        if (frame_cnt == 3'd0) begin
          if (rx_byte[7:6] == 2'b01) frame_n = 3'd1;
        end else if (frame_cnt == 3'd5) begin
          frame_n = 3'd0; cmd_done = 1'b1; state_n = RSP_GAP; cnt_n = 10'd0;
        end else begin
          frame_n = frame_cnt + 3'd1;
        end
      end
      RSP_GAP: begin
        if (cnt == NCR_LAST) begin
          state_n = RSP_TX; cnt_n = 10'd0; tx_next = rsp_q[0];
        end else cnt_n = cnt + 10'd1;
      end
      RSP_TX: begin
        if (cnt == {7'd0, rsp_last}) begin
          cnt_n = 10'd0;
          case (post)
            POST_RD: state_n = RD_GAP;
            POST_WR: state_n = WR_TOKEN;
            default: state_n = CMD_RX;
          endcase
        end else begin
          cnt_n = cnt + 10'd1; tx_next = rsp_q[cnt[2:0] + 3'd1];
        end
      end
      RD_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = RD_TOKEN; tx_next = 8'hFE;
        end else cnt_n = cnt + 10'd1;
      end
      RD_TOKEN: begin
        state_n = RD_DATA; cnt_n = 10'd0; tx_next = bus.mem_rd_data; rd_adv = 1'b1;
      end
      RD_DATA: begin
        if (cnt == 10'd511) begin
          state_n = RD_CRC; cnt_n = 10'd0;
        end else begin
          cnt_n = cnt + 10'd1; tx_next = bus.mem_rd_data; rd_adv = 1'b1;
        end
      end
      RD_CRC: begin
        if (cnt == 10'd1) state_n = CMD_RX;
        else cnt_n = cnt + 10'd1;
      end
      WR_TOKEN: begin
        if (rx_byte == 8'hFE) begin
          state_n = WR_DATA; cnt_n = 10'd0;
        end
      end
      WR_DATA: begin
        wr_stb = 1'b1;
        if (cnt == 10'd511) begin
          state_n = WR_CRC; cnt_n = 10'd0;
        end else cnt_n = cnt + 10'd1;
      end
      WR_CRC: begin
        if (cnt == 10'd1) begin
          state_n = WR_RESP; tx_next = 8'hE5;
        end else cnt_n = cnt + 10'd1;
      end
      WR_RESP: begin
        state_n = WR_BUSY; cnt_n = 10'd0; tx_next = 8'h00;
      end
      WR_BUSY: begin
        if (cnt == BUSY_LAST) state_n = CMD_RX;
        else begin
          cnt_n = cnt + 10'd1; tx_next = 8'h00;
        end
      end
      default: state_n = CMD_RX;
    endcase
  end

  // Command decode: response bytes, data phase and card-state updates for the completed frame
  always_comb begin
    illegal = 1'b0; init_n = init_q; acmd_n = acmd_cnt; post_n = POST_NONE; last_n = 3'd0;
    rsp_n = '1;
    case (cmd_idx_q)
      6'd0: begin init_n = 1'b0; acmd_n = RETRY_INIT; end
      6'd8: begin
        last_n = 3'd4; rsp_n[1] = 8'h00; rsp_n[2] = 8'h00;
        rsp_n[3] = {4'b0, arg_q[11:8]}; rsp_n[4] = arg_q[7:0];
      end
      6'd55: ;
      6'd41: begin
        if (!app_flag) illegal = 1'b1;
        else if (acmd_cnt != 8'd0) acmd_n = acmd_cnt - 8'd1;
        else init_n = 1'b1;
      end
      6'd58: begin
        last_n = 3'd4; rsp_n[1] = init_q ? 8'hC0 : 8'h00;
        rsp_n[2] = 8'hFF; rsp_n[3] = 8'h80; rsp_n[4] = 8'h00;
      end
      6'd17: if (init_q) post_n = POST_RD; else illegal = 1'b1;
      6'd24: if (init_q) post_n = POST_WR; else illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    rsp_n[0] = {5'b0, illegal, 1'b0, ~init_n};
  end

  // Frame capture, card state, memory index and write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_idx_q <= 6'd0; arg_q <= 32'd0; init_q <= 1'b0; app_flag <= 1'b0;
      acmd_cnt <= RETRY_INIT; rsp_q <= '1; rsp_last <= 3'd0; post <= POST_NONE;
      blk_addr_q <= 32'd0; mem_idx_q <= 9'd0; wr_en_q <= 1'b0; wr_data_q <= 8'd0;
      strobe_q <= 1'b0; cmd_index_q <= 6'd0;
    end else begin
      strobe_q <= 1'b0;
      wr_en_q  <= 1'b0;
      if (wr_en_q) mem_idx_q <= mem_idx_q + 9'd1;
      if (byte_done) begin
        if (state == CMD_RX && frame_cnt == 3'd0 && rx_byte[7:6] == 2'b01) cmd_idx_q <= rx_byte[5:0];
        if (state == CMD_RX && frame_cnt >= 3'd1 && frame_cnt <= 3'd4) arg_q <= {arg_q[23:0], rx_byte};
        if (cmd_done) begin
          strobe_q <= 1'b1; cmd_index_q <= cmd_idx_q;
          init_q <= init_n; acmd_cnt <= acmd_n; app_flag <= (cmd_idx_q == 6'd55);
          rsp_q <= rsp_n; rsp_last <= last_n; post <= post_n;
          if (post_n != POST_NONE) begin
            blk_addr_q <= arg_q; mem_idx_q <= 9'd0;
          end
        end
        if (rd_adv) mem_idx_q <= mem_idx_q + 9'd1;
        if (wr_stb) begin
          wr_en_q <= 1'b1; wr_data_q <= rx_byte;
        end
      end
    end
  end

  assign bus.miso        = tx_sr[7];
  assign bus.blk_addr    = blk_addr_q;
  assign bus.mem_idx     = mem_idx_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.initialized = init_q;
  assign bus.cmd_strobe  = strobe_q;
  assign bus.cmd_index   = cmd_index_q;
endmodule

// File: tb/tb_sd_spi_card_responder.sv
// tb/tb_sd_spi_card_responder.sv - directed SPI host bench for the SD card responder
module tb_sd_spi_card_responder;
  logic clk = 1'b0;
  logic rst;
  sd_spi_card_responder_if bus();

  sd_spi_card_responder dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int strobe_cnt = 0;
  int wr_n = 0;
  logic [8:0] wr_idx [1024];
  logic [7:0] wr_dat [1024];

  // Backing memory: byte value is the index, one clock of read latency
  always @(posedge clk) bus.mem_rd_data <= bus.mem_idx[7:0];

  // Strobe monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.cmd_strobe) strobe_cnt++;
    if (bus.mem_wr_en) begin
      if (wr_n < 1024) begin
        wr_idx[wr_n] = bus.mem_idx;
        wr_dat[wr_n] = bus.mem_wr_data;
      end
      wr_n++;
    end
  end

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = tx[i];
      #40 bus.spi_clk = 1'b1;
      rx[i] = bus.miso;
      #40 bus.spi_clk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [7:0] d;
    xfer({2'b01, idx}, d);
    xfer(arg[31:24], d);
    xfer(arg[23:16], d);
    xfer(arg[15:8], d);
    xfer(arg[7:0], d);
    xfer(crc, d);
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #100 bus.cs = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.cs = 1'b1; bus.spi_clk = 1'b0; bus.mosi = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.miso !== 1'b1) $display("FAIL reset_miso got %b exp 1", bus.miso); else passed++;
    checks++; if (bus.initialized !== 1'b0) $display("FAIL reset_init got %b exp 0", bus.initialized); else passed++;
    checks++; if (bus.cmd_strobe !== 1'b0) $display("FAIL reset_strobe got %b exp 0", bus.cmd_strobe); else passed++;
    checks++; if (bus.mem_wr_en !== 1'b0) $display("FAIL reset_wr_en got %b exp 0", bus.mem_wr_en); else passed++;
    checks++; if (bus.blk_addr !== 32'd0) $display("FAIL reset_blk_addr got %h exp 0", bus.blk_addr); else passed++;
    checks++; if (bus.mem_idx !== 9'd0) $display("FAIL reset_mem_idx got %h exp 0", bus.mem_idx); else passed++;
    checks++; if (bus.cmd_index !== 6'd0) $display("FAIL reset_cmd_index got %h exp 0", bus.cmd_index); else passed++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.miso !== 1'b1) $display("FAIL idle_miso got %b exp 1", bus.miso); else passed++;
  endtask

  task automatic test_cmd0();
    logic [7:0] rx;
    int s0;
    s0 = strobe_cnt;
    cs_low();
    send_cmd(6'd0, 32'd0, 8'h95);
    xfer(8'hFF, rx);
    checks++; if (rx !== 8'hFF) $display("FAIL cmd0_ncr got %h exp ff", rx); else passed++;
    xfer(8'hFF, rx);
    checks++; if (rx !== 8'h01) $display("FAIL cmd0_r1 got %h exp 01", rx); else passed++;
    checks++; if (strobe_cnt - s0 !== 1) $display("FAIL cmd0_strobes got %0d exp 1", strobe_cnt - s0); else passed++;
    checks++; if (bus.cmd_index !== 6'd0) $display("FAIL cmd0_index got %0d exp 0", bus.cmd_index); else passed++;
    cs_high();
  endtask

  task automatic test_cmd8();
    logic [7:0] rx;
    logic [7:0] exp_b [6];
    exp_b = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    cs_low();
    send_cmd(6'd8, 32'h0000_01AA, 8'h87);
    for (int i = 0; i < 6; i++) begin
      xfer(8'hFF, rx);
      checks++; if (rx !== exp_b[i]) $display("FAIL cmd8_byte%0d got %h exp %h", i, rx, exp_b[i]); else passed++;
    end
    checks++; if (bus.cmd_index !== 6'd8) $display("FAIL cmd8_index got %0d exp 8", bus.cmd_index); else passed++;
    cs_high();
  endtask

  task automatic test_acmd41();
    logic [7:0] rx;
    logic [7:0] exp_r1 [3];
    logic       exp_init [3];
    logic [7:0] exp_ocr [6];
    exp_r1   = '{8'h01, 8'h01, 8'h00};
    exp_init = '{1'b0, 1'b0, 1'b1};
    exp_ocr  = '{8'hFF, 8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00};
    cs_low();
    for (int r = 0; r < 3; r++) begin
      send_cmd(6'd55, 32'd0, 8'h65);
      xfer(8'hFF, rx);
      xfer(8'hFF, rx);
      checks++; if (rx !== 8'h01) $display("FAIL cmd55_r1_%0d got %h exp 01", r, rx); else passed++;
      send_cmd(6'd41, 32'h4000_0000, 8'h77);
      xfer(8'hFF, rx);
      xfer(8'hFF, rx);
      checks++; if (rx !== exp_r1[r]) $display("FAIL acmd41_r1_%0d got %h exp %h", r, rx, exp_r1[r]); else passed++;
      checks++; if (bus.initialized !== exp_init[r]) $display("FAIL acmd41_init_%0d got %b exp %b", r, bus.initialized, exp_init[r]); else passed++;
    end
    send_cmd(6'd58, 32'd0, 8'hFD);
    for (int i = 0; i < 6; i++) begin
      xfer(8'hFF, rx);
      checks++; if (rx !== exp_ocr[i]) $display("FAIL cmd58_byte%0d got %h exp %h", i, rx, exp_ocr[i]); else passed++;
    end
    cs_high();
  endtask

  task automatic test_read();
    logic [7:0] rx;
    logic [7:0] hdr [5];
    hdr = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFE};
    cs_low();
    send_cmd(6'd17, 32'd5, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      xfer(8'hFF, rx);
      checks++; if (rx !== hdr[i]) $display("FAIL rd_hdr%0d got %h exp %h", i, rx, hdr[i]); else passed++;
    end
    for (int i = 0; i < 512; i++) begin
      xfer(8'hFF, rx);
      checks++; if (rx !== 8'(i)) $display("FAIL rd_data%0d got %h exp %h", i, rx, 8'(i)); else passed++;
    end
    for (int i = 0; i < 2; i++) begin
      xfer(8'hFF, rx);
      checks++; if (rx !== 8'hFF) $display("FAIL rd_crc%0d got %h exp ff", i, rx); else passed++;
    end
    checks++; if (bus.blk_addr !== 32'd5) $display("FAIL rd_blk_addr got %h exp 5", bus.blk_addr); else passed++;
    checks++; if (bus.mem_idx !== 9'd0) $display("FAIL rd_idx_wrap got %0d exp 0", bus.mem_idx); else passed++;
    cs_high();
  endtask

  task automatic test_write();
    logic [7:0] rx;
    logic [7:0] tail [6];
    int w0;
    tail = '{8'hE5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    w0 = wr_n;
    cs_low();
    send_cmd(6'd24, 32'd9, 8'hFF);
    xfer(8'hFF, rx);
    xfer(8'hFF, rx);
    checks++; if (rx !== 8'h00) $display("FAIL wr_r1 got %h exp 00", rx); else passed++;
    xfer(8'hFF, rx);
    xfer(8'hFE, rx);
    for (int i = 0; i < 512; i++) xfer(8'(i) ^ 8'h5A, rx);
    xfer(8'h12, rx);
    xfer(8'h34, rx);
    for (int i = 0; i < 6; i++) begin
      xfer(8'hFF, rx);
      checks++; if (rx !== tail[i]) $display("FAIL wr_tail%0d got %h exp %h", i, rx, tail[i]); else passed++;
    end
    checks++; if (wr_n - w0 !== 512) $display("FAIL wr_count got %0d exp 512", wr_n - w0); else passed++;
    for (int i = 0; i < 512; i++) begin
      checks++;
      if ({wr_idx[w0 + i], wr_dat[w0 + i]} !== {9'(i), 8'(i) ^ 8'h5A})
        $display("FAIL wr_entry%0d got idx %0d data %h exp idx %0d data %h", i, wr_idx[w0 + i], wr_dat[w0 + i], i, 8'(i) ^ 8'h5A);
      else passed++;
    end
    checks++; if (bus.blk_addr !== 32'd9) $display("FAIL wr_blk_addr got %h exp 9", bus.blk_addr); else passed++;
    cs_high();
  endtask

  task automatic test_cs_abort();
    logic [7:0] rx;
    logic [7:0] exp_ocr [6];
    exp_ocr = '{8'hFF, 8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00};
    cs_low();
    send_cmd(6'd17, 32'd5, 8'hFF);
    for (int i = 0; i < 100; i++) xfer(8'hFF, rx);
    cs_high();
    checks++; if (bus.miso !== 1'b1) $display("FAIL abort_miso got %b exp 1", bus.miso); else passed++;
    checks++; if (bus.initialized !== 1'b1) $display("FAIL abort_init got %b exp 1", bus.initialized); else passed++;
    cs_low();
    send_cmd(6'd58, 32'd0, 8'hFD);
    for (int i = 0; i < 6; i++) begin
      xfer(8'hFF, rx);
      checks++; if (rx !== exp_ocr[i]) $display("FAIL abort_cmd58_byte%0d got %h exp %h", i, rx, exp_ocr[i]); else passed++;
    end
    cs_high();
  endtask

  task automatic test_uninit();
    logic [7:0] rx;
    cs_low();
    send_cmd(6'd0, 32'd0, 8'h95);
    xfer(8'hFF, rx);
    xfer(8'hFF, rx);
    checks++; if (rx !== 8'h01) $display("FAIL reinit_r1 got %h exp 01", rx); else passed++;
    checks++; if (bus.initialized !== 1'b0) $display("FAIL reinit_init got %b exp 0", bus.initialized); else passed++;
    send_cmd(6'd17, 32'd5, 8'hFF);
    xfer(8'hFF, rx);
    xfer(8'hFF, rx);
    checks++; if (rx !== 8'h05) $display("FAIL uninit_rd_r1 got %h exp 05", rx); else passed++;
    for (int i = 0; i < 6; i++) begin
      xfer(8'hFF, rx);
      checks++; if (rx !== 8'hFF) $display("FAIL uninit_no_token%0d got %h exp ff", i, rx); else passed++;
    end
    send_cmd(6'd55, 32'd0, 8'h65);
    xfer(8'hFF, rx);
    xfer(8'hFF, rx);
    send_cmd(6'd8, 32'h0000_01AA, 8'h87);
    for (int i = 0; i < 6; i++) xfer(8'hFF, rx);
    send_cmd(6'd41, 32'd0, 8'h77);
    xfer(8'hFF, rx);
    xfer(8'hFF, rx);
    checks++; if (rx !== 8'h05) $display("FAIL plain41_r1 got %h exp 05", rx); else passed++;
    checks++; if (bus.cmd_index !== 6'd41) $display("FAIL plain41_index got %0d exp 41", bus.cmd_index); else passed++;
    cs_high();
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_acmd41();
    test_read();
    test_write();
    test_cs_abort();
    test_uninit();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
